// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch slice.
//   ADDR_W / DATA_W      : instruction word-address and instruction widths
//   IF_MEM_DEPTH         : default number of instruction words
//   IF_RESET_PC          : default PC after reset / illegal redirect
//   fetch_entry_t        : {pc, instr} pair held in the fetch buffer
//   fetch_action_t       : per-cycle action chosen by the fetch control
package instruction_fetch_pkg;

    localparam int unsigned ADDR_W       = 16;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned IF_MEM_DEPTH = 256;
    localparam int unsigned IF_RESET_PC  = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_PUSH,
        FETCH_REDIRECT
    } fetch_action_t;

endpackage

// File: rtl/instruction_fetch_fifo.sv
// Synchronous FIFO of fetch entries.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push/entry   : write entry (accepted when not full, or full with pop)
//   pop          : remove head (ignored when empty)
//   flush        : empty the buffer; wins over push and pop
//   head         : oldest entry, head_valid when count != 0
//   count        : number of stored entries
module fetch_fifo
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  fetch_entry_t               entry,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic                       head_valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop & ~flush & (count != '0);
        do_push = push & ~flush & ((count < CNT_W'(DEPTH)) | do_pop);
    end

    // Storage is reset so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head       = mem[rd_ptr];
    assign head_valid = (count != '0);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, reads instruction memory and buffers
// {pc, instruction} pairs for decode via a valid/ready handshake.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   inst_address / read_data   : instruction memory port (combinational read)
//   redirect_valid/redirect_pc : branch/jump target, flushes the buffer
//   halt                       : stop fetching (buffer still drains)
//   out_valid/out_instr/out_pc : buffer head toward decode, out_ready accepts
//   addr_err                   : sticky, set by an out-of-range redirect
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned MEM_DEPTH  = IF_MEM_DEPTH,
    parameter int unsigned RESET_PC   = IF_RESET_PC,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] inst_address,
    input  logic [DATA_W-1:0] read_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              out_ready,
    output logic              addr_err
);

    localparam int unsigned       CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] PC_LAST  = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W:0]   PC_LIMIT = (ADDR_W + 1)'(MEM_DEPTH);

    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  count;
    logic              pop;
    logic              space;
    fetch_action_t     action;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    // Redirect outranks fetching; a full buffer still accepts a push when
    // the head leaves in the same cycle.
    always_comb begin
        pop    = out_valid & out_ready;
        space  = (count < CNT_W'(FIFO_DEPTH)) | pop;
        action = FETCH_IDLE;
        if (redirect_valid) begin
            action = FETCH_REDIRECT;
        end else if (!halt && space) begin
            action = FETCH_PUSH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= PC_RESET;
            addr_err <= 1'b0;
        end else begin
            case (action)
                FETCH_REDIRECT: begin
                    if ({1'b0, redirect_pc} < PC_LIMIT) begin
                        pc <= redirect_pc;
                    end else begin
                        pc       <= PC_RESET;
                        addr_err <= 1'b1;
                    end
                end
                FETCH_PUSH: begin
                    pc <= (pc == PC_LAST) ? '0 : pc + ADDR_W'(1);
                end
                default: begin
                    pc <= pc;
                end
            endcase
        end
    end

    assign inst_address = pc;

    always_comb begin
        push_entry       = '0;
        push_entry.pc    = pc;
        push_entry.instr = read_data;
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (action == FETCH_PUSH),
        .entry      (push_entry),
        .pop        (pop),
        .flush      (action == FETCH_REDIRECT),
        .head       (head),
        .head_valid (out_valid),
        .count      (count)
    );

    assign out_instr = head.instr;
    assign out_pc    = head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic [15:0] inst_address;
    logic [31:0] read_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [15:0] out_pc;
    logic        out_ready;
    logic        addr_err;

    logic [31:0] ram [256];
    int          tests;
    int          fails;

    instruction_fetch #(
        .MEM_DEPTH  (256),
        .RESET_PC   (0),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inst_address   (inst_address),
        .read_data      (read_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .addr_err       (addr_err)
    );

    assign read_data = ram[inst_address[7:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input int unsigned k);
        return (k == 0) ? 32'h2000_0004 : 32'hA000_0000 + k;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests = 0;
        fails = 0;
        for (int k = 0; k < 256; k++) ram[k] = mem_word(k);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;
        out_ready      = 1'b0;

        // Reset state
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_addr", inst_address, 0);
        check("rst_err", addr_err, 0);
        check("rst_pc", out_pc, 0);
        check("rst_instr", out_instr, 0);

        // Free-running fetch, one per cycle
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("run_valid", out_valid, 1);
            check("run_pc", out_pc, k);
            check("run_instr", out_instr, mem_word(k));
        end

        // Back-pressure: buffer fills to two, pc holds at 2
        out_ready = 1'b0;
        do_reset();
        step();
        check("bp_addr1", inst_address, 1);
        step();
        check("bp_addr2", inst_address, 2);
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_hold_addr", inst_address, 2);
            check("bp_hold_pc", out_pc, 0);
            check("bp_hold_instr", out_instr, 32'h2000_0004);
            check("bp_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            step();
            check("bp_rel_valid", out_valid, 1);
            check("bp_rel_pc", out_pc, k);
            check("bp_rel_instr", out_instr, mem_word(k));
        end
        check("bp_pc5", inst_address, 5);

        // Redirect with buffered entries and a concurrent pop
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        step();
        redirect_valid = 1'b0;
        check("rd_flush", out_valid, 0);
        check("rd_addr", inst_address, 16'h0040);
        step();
        check("rd_valid", out_valid, 1);
        check("rd_pc40", out_pc, 16'h0040);
        check("rd_instr40", out_instr, 32'hA000_0040);
        step();
        check("rd_pc41", out_pc, 16'h0041);

        // Wrap at the last legal word
        redirect_valid = 1'b1;
        redirect_pc    = 16'h00FF;
        step();
        redirect_valid = 1'b0;
        check("wr_addr", inst_address, 16'h00FF);
        step();
        check("wr_pcff", out_pc, 16'h00FF);
        check("wr_instrff", out_instr, 32'hA000_00FF);
        check("wr_addr0", inst_address, 0);
        step();
        check("wr_pc0", out_pc, 0);
        check("wr_instr0", out_instr, 32'h2000_0004);
        check("wr_noerr", addr_err, 0);

        // Out-of-range redirect
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0100;
        step();
        redirect_valid = 1'b0;
        check("oor_err", addr_err, 1);
        check("oor_addr", inst_address, 0);
        check("oor_flush", out_valid, 0);
        step();
        check("oor_valid", out_valid, 1);
        check("oor_pc", out_pc, 0);
        step();
        check("oor_sticky", addr_err, 1);
        check("oor_pc1", out_pc, 1);

        // Halt: buffer drains, pc holds at 2
        halt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("halt_addr", inst_address, 2);
        end
        check("halt_empty", out_valid, 0);
        halt = 1'b0;
        step();
        check("halt_res_valid", out_valid, 1);
        check("halt_res_pc", out_pc, 2);
        check("halt_res_addr", inst_address, 3);

        // Redirect while halted
        halt           = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0010;
        step();
        redirect_valid = 1'b0;
        check("hrd_addr", inst_address, 16'h0010);
        check("hrd_flush", out_valid, 0);
        step();
        check("hrd_hold", inst_address, 16'h0010);
        check("hrd_empty", out_valid, 0);
        halt = 1'b0;
        step();
        check("hrd_pc", out_pc, 16'h0010);
        check("hrd_instr", out_instr, 32'hA000_0010);

        // Asynchronous reset between edges
        step();
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_addr", inst_address, 0);
        check("ar_err", addr_err, 0);
        #2;
        rst_n = 1'b1;
        step();
        check("ar_pc0", out_pc, 0);
        check("ar_instr0", out_instr, 32'h2000_0004);
        step();
        check("ar_pc1", out_pc, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Initiator side of the instruction memory read port.
- Owns the program counter and drives the 16-bit word address into the instruction memory.
- Captures the 32-bit combinational read data and presents {pc, instruction} pairs to decode through a valid/ready handshake.
- Buffers up to FIFO_DEPTH fetched instructions; supports branch/jump redirect (with flush) and halt.

Parameters:
- ADDR_W, 16, instruction word-address width (matches memory address port).
- DATA_W, 32, instruction width.
- MEM_DEPTH, 256, number of instruction words; valid PCs are 0..MEM_DEPTH-1.
- RESET_PC, 0, PC value after reset and after an illegal redirect.
- FIFO_DEPTH, 2, fetch buffer entries (power of two, >=2).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- inst_address  out  ADDR_W  word address to instruction memory; always equals pc.
- read_data  in  DATA_W  instruction from memory, combinational on inst_address.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  ADDR_W  target word address.
- halt  in  1  suppress new fetches while high.
- out_valid  out  1  buffer head valid.
- out_instr  out  DATA_W  buffer head instruction.
- out_pc  out  ADDR_W  address of out_instr.
- out_ready  in  1  decode accepts head.
- addr_err  out  1  sticky; set by an out-of-range redirect.

Behaviour:
- Reset (async assert, sync-release use):
  - pc=RESET_PC, FIFO empty, out_valid=0, out_instr=0, out_pc=0, addr_err=0.
  - inst_address=RESET_PC immediately.
- Definitions:
  - pop = out_valid & out_ready.
  - space = (count<FIFO_DEPTH) | pop.
  - fetch = ~halt & space & ~redirect_valid.
- On fetch:
  - Push {pc, read_data} at the clock edge.
  - pc <= (pc==MEM_DEPTH-1) ? 0 : pc+1 (wrap, no error).
- Latency: instruction at pc is visible on out_* one cycle after the fetch edge. Back-to-back fetch with out_ready=1 gives one instruction per cycle.
- Full with no pop: no push, pc holds, inst_address stable.
- Full with pop in the same cycle: push and pop both occur, count unchanged.
- Empty: out_valid=0. out_instr/out_pc hold their last values (don't-care for checking).
- Handshake: while out_valid=1 and out_ready=0, out_instr and out_pc are stable.
- Redirect (highest priority):
  - FIFO flushed (count<=0), any concurrent pop is discarded, no push that cycle.
  - If redirect_pc < MEM_DEPTH: pc <= redirect_pc.
  - Otherwise: pc <= RESET_PC and addr_err <= 1.
  - The first instruction from the target appears on out_* two cycles after the redirect edge, provided halt=0.
- Halt:
  - No pushes and pc holds.
  - Buffer still drains via out_ready.
  - A redirect during halt still updates pc and flushes.
- addr_err: cleared only by reset.
- Counter widths: count is clog2(FIFO_DEPTH)+1 bits. pc increment is computed at ADDR_W, and wrap is explicit at MEM_DEPTH-1.
- Reset mid-operation: all state returns to reset values asynchronously; pending buffer contents are lost.

Decomposition:
- Shared package: ADDR_W, DATA_W, MEM_DEPTH, RESET_PC; a fetch-entry typedef {pc[ADDR_W], instr[DATA_W]}.
- One sub-module, fetch_fifo:
  - Synchronous FIFO of fetch entries with push, pop, flush, count, and head output.
  - Flush has priority over push and pop.
- The top level holds pc, fetch/redirect control and addr_err.

Test Plan:
- Memory model preloaded ram[0]=32'h2000_0004, ram[k]=32'hA000_0000+k; out_ready=1 after reset release -> out_pc 0,1,2,3 on consecutive cycles; first out_instr=32'h2000_0004, then 32'hA000_0001…
- out_ready=0 for 5 cycles from reset -> count saturates at 2, inst_address holds 2, out_pc stays 0; release -> out_pc 0,1,2,3 with no gaps and no drops.
- At pc=5, pulse redirect_valid with redirect_pc=16'h0040 while out_valid=1 -> buffered entries discarded; next valid out_pc=16'h0040 two cycles later, then 0x41.
- Redirect to 16'h00FF, free-run -> out_pc 0xFF then 0x00, addr_err stays 0; then redirect to 16'h0100 -> addr_err=1, next out_pc=0.
- halt=1 for 4 cycles with out_ready=1 -> buffer drains, out_valid drops to 0, inst_address constant; halt=0 -> fetch resumes at the held pc.
- Deassert rst_n mid-stream (async, between edges) -> out_valid=0, inst_address=0, addr_err=0 immediately; after release the sequence restarts at out_pc 0.
